// File: rtl/accumulator.sv
// rtl/accumulator.sv - sixteen-operand integer/binary32 reduction with four lane adders and one combine adder
// Optional debug port drive: ACCUM_DEBUG_PORTS_EN (undefined ties in0/in1/sum0..sum3 to zero)
module accumulator #(
  parameter int FLOAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         EN,
  input  logic [511:0] vals,
  output logic [31:0]  sum,
  output logic         rdy,
  output logic [31:0]  in0,
  output logic [31:0]  in1,
  output logic [31:0]  sum0,
  output logic [31:0]  sum1,
  output logic [31:0]  sum2,
  output logic [31:0]  sum3
);

  typedef enum logic [2:0] {
    S_IDLE, S_LANE1, S_LANE2, S_LANE3, S_COMB1, S_COMB2, S_COMB3, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] lane_q [4];
  logic [31:0] lane_d [4];
  logic [31:0] ops_q [4][3];
  logic [31:0] ops_d [4][3];
  logic [31:0] partial_q, partial_d;
  logic [31:0] sum_q, sum_d;
  logic        rdy_q, rdy_d;
  logic [31:0] comb_a, comb_b, comb_r;
  logic        lane_go;
  logic [1:0]  lane_step;

  // Binary32 add: RNE, subnormals flushed to signed zero, single quiet NaN.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic               sx, sy;
    logic [7:0]         ex, ey, d;
    logic [23:0]        mx, my;
    logic [49:0]        ysh;
    logic [26:0]        x27, y27, n27;
    logic [27:0]        s28;
    logic [24:0]        m25;
    logic [22:0]        mant;
    logic signed [9:0]  e;
    logic [4:0]         lz;
    logic               rnd;
    logic [31:0]        r;
    r = '0;
    if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0) ||
        (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31])) begin
      r = 32'h7FC00000;
    end else if (a[30:23] == 8'hFF) begin
      r = a;
    end else if (b[30:23] == 8'hFF) begin
      r = b;
    end else if (a[30:23] == 8'h00 && b[30:23] == 8'h00) begin
      r = {a[31] & b[31], 31'b0};
    end else if (a[30:23] == 8'h00) begin
      r = b;
    end else if (b[30:23] == 8'h00) begin
      r = a;
    end else begin
      if (a[30:0] >= b[30:0]) begin
        sx = a[31]; ex = a[30:23]; mx = {1'b1, a[22:0]};
        sy = b[31]; ey = b[30:23]; my = {1'b1, b[22:0]};
      end else begin
        sx = b[31]; ex = b[30:23]; mx = {1'b1, b[22:0]};
        sy = a[31]; ey = a[30:23]; my = {1'b1, a[22:0]};
      end
      d   = ex - ey;
      ysh = {my, 26'b0} >> d;
      y27 = (d > 8'd30) ? 27'd1 : {ysh[49:24], |ysh[23:0]};
      x27 = {mx, 3'b000};
      s28 = (sx == sy) ? ({1'b0, x27} + {1'b0, y27}) : ({1'b0, x27} - {1'b0, y27});
      if (s28 == '0) begin
        r = '0;
      end else begin
        e  = signed'({2'b00, ex});
        lz = '0;
        if (s28[27]) begin
          n27 = {s28[27:2], s28[1] | s28[0]};
          e   = e + 10'sd1;
        end else begin
          for (int i = 0; i < 27; i++) begin
            if (s28[i]) lz = 5'(26 - i);
          end
          n27 = s28[26:0] << lz;
          e   = e - signed'({5'b00000, lz});
        end
        rnd = n27[2] & (n27[1] | n27[0] | n27[3]);
        m25 = {1'b0, n27[26:3]} + {24'b0, rnd};
        if (m25[24]) begin
          mant = m25[23:1];
          e    = e + 10'sd1;
        end else begin
          mant = m25[22:0];
        end
        if (e >= 10'sd255)    r = {sx, 8'hFF, 23'b0};
        else if (e <= 10'sd0) r = {sx, 31'b0};
        else                  r = {sx, e[7:0], mant};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
    if (FLOAT != 0) return fp_add(a, b);
    return a + b;
  endfunction

  always_comb begin
    comb_a = '0;
    comb_b = '0;
    case (state_q)
      S_COMB1: begin comb_a = lane_q[0];  comb_b = lane_q[1]; end
      S_COMB2: begin comb_a = partial_q;  comb_b = lane_q[2]; end
      S_COMB3: begin comb_a = partial_q;  comb_b = lane_q[3]; end
      default: ;
    endcase
  end

  assign comb_r = add32(comb_a, comb_b);

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    ops_d     = ops_q;
    partial_d = partial_q;
    sum_d     = sum_q;
    rdy_d     = rdy_q;
    lane_go   = 1'b0;
    lane_step = 2'd0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (EN) begin
          // v[4K] seeds lane K directly; only the remaining twelve operands need storing.
          for (int k = 0; k < 4; k++) begin
            lane_d[k] = vals[511 - 128*k -: 32];
            for (int s = 0; s < 3; s++) ops_d[k][s] = vals[511 - 32*(4*k + s + 1) -: 32];
          end
          rdy_d   = 1'b0;
          state_d = S_LANE1;
        end
      end
      S_LANE1: begin lane_go = 1'b1; lane_step = 2'd0; state_d = S_LANE2; end
      S_LANE2: begin lane_go = 1'b1; lane_step = 2'd1; state_d = S_LANE3; end
      S_LANE3: begin lane_go = 1'b1; lane_step = 2'd2; state_d = S_COMB1; end
      S_COMB1: begin partial_d = comb_r; state_d = S_COMB2; end
      S_COMB2: begin partial_d = comb_r; state_d = S_COMB3; end
      S_COMB3: begin sum_d = comb_r; rdy_d = 1'b1; state_d = S_DONE; end
      default: state_d = S_IDLE;
    endcase
    if (lane_go) begin
      for (int k = 0; k < 4; k++) lane_d[k] = add32(lane_q[k], ops_q[k][lane_step]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      partial_q <= '0;
      sum_q     <= '0;
      rdy_q     <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        lane_q[k] <= '0;
        for (int s = 0; s < 3; s++) ops_q[k][s] <= '0;
      end
    end else begin
      state_q   <= state_d;
      partial_q <= partial_d;
      sum_q     <= sum_d;
      rdy_q     <= rdy_d;
      lane_q    <= lane_d;
      ops_q     <= ops_d;
    end
  end

  assign sum = sum_q;
  assign rdy = rdy_q;

`ifdef ACCUM_DEBUG_PORTS_EN
  assign in0  = comb_a;
  assign in1  = comb_b;
  assign sum0 = lane_q[0];
  assign sum1 = lane_q[1];
  assign sum2 = lane_q[2];
  assign sum3 = lane_q[3];
`else
  assign in0  = 32'h0;
  assign in1  = 32'h0;
  assign sum0 = 32'h0;
  assign sum1 = 32'h0;
  assign sum2 = 32'h0;
  assign sum3 = 32'h0;
`endif

endmodule

// File: tb/tb_accumulator.sv
// tb/tb_accumulator.sv - randomized bench for accumulator, integer and float instances side by side
module tb_accumulator;
  logic         clk = 1'b0;
  logic         rst;
  logic         EN;
  logic [511:0] vals;
  logic [31:0]  i_sum, i_in0, i_in1, i_s0, i_s1, i_s2, i_s3;
  logic [31:0]  f_sum, f_in0, f_in1, f_s0, f_s1, f_s2, f_s3;
  logic         i_rdy, f_rdy;

  accumulator #(.FLOAT(0)) u_int (
    .clk(clk), .rst(rst), .EN(EN), .vals(vals), .sum(i_sum), .rdy(i_rdy),
    .in0(i_in0), .in1(i_in1), .sum0(i_s0), .sum1(i_s1), .sum2(i_s2), .sum3(i_s3));

  accumulator #(.FLOAT(1)) u_flt (
    .clk(clk), .rst(rst), .EN(EN), .vals(vals), .sum(f_sum), .rdy(f_rdy),
    .in0(f_in0), .in1(f_in1), .sum0(f_s0), .sum1(f_s1), .sum2(f_s2), .sum3(f_s3));

  always #5 clk = ~clk;

`ifdef ACCUM_DEBUG_PORTS_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] v [16];
  logic [31:0] e_lane [2][4];
  logic [31:0] e_p1 [2];
  logic [31:0] e_p2 [2];
  logic [31:0] e_sum [2];
  logic [31:0] o_sum [2][14];
  logic        o_rdy [2][14];
  logic [31:0] o_in0 [2][14];
  logic [31:0] o_in1 [2][14];
  logic [31:0] o_lane [2][4];
  logic [31:0] prev [2];

  function automatic logic [31:0] dbg(input logic [31:0] x);
    return DBG ? x : 32'h0;
  endfunction

  // Reference float add: exact sum in double precision, then rounded once to binary32.
  function automatic real f2r(input logic [31:0] a);
    logic [63:0] d;
    if (a[30:23] == 8'h00) return 0.0;
    d = {a[31], 11'(int'(a[30:23]) + 896), a[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic [63:0] d;
    logic [22:0] keep;
    logic [28:0] rest;
    logic [24:0] m;
    logic [22:0] mant;
    int          e;
    if (x == 0.0) return 32'h0;
    d    = $realtobits(x);
    e    = int'(d[62:52]) - 896;
    keep = d[51:29];
    rest = d[28:0];
    m    = {2'b01, keep};
    if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && keep[0])) m = m + 25'd1;
    if (m[24]) begin e = e + 1; mant = m[23:1]; end
    else mant = m[22:0];
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    if (e <= 0) return {d[63], 31'b0};
    return {d[63], 8'(e), mant};
  endfunction

  function automatic logic [31:0] fadd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] fa, fb;
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 32'h7FC00000;
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) return 32'h7FC00000;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    fa = (a[30:23] == 8'h00) ? {a[31], 31'b0} : a;
    fb = (b[30:23] == 8'h00) ? {b[31], 31'b0} : b;
    if (fa[30:0] == 0 && fb[30:0] == 0) return {fa[31] & fb[31], 31'b0};
    return r2f(f2r(fa) + f2r(fb));
  endfunction

  function automatic logic [31:0] radd(input int m, input logic [31:0] a, input logic [31:0] b);
    return (m == 1) ? fadd_ref(a, b) : a + b;
  endfunction

  task automatic model;
    logic [31:0] acc;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 4; k++) begin
        acc = v[4*k];
        for (int s = 1; s < 4; s++) acc = radd(m, acc, v[4*k+s]);
        e_lane[m][k] = acc;
      end
      e_p1[m]  = radd(m, e_lane[m][0], e_lane[m][1]);
      e_p2[m]  = radd(m, e_p1[m], e_lane[m][2]);
      e_sum[m] = radd(m, e_p2[m], e_lane[m][3]);
    end
    acc = 32'h0;
    for (int i = 0; i < 16; i++) acc = acc + v[i];
    e_sum[0] = acc;
  endtask

  function automatic logic [31:0] rand_f(input int center);
    logic [31:0] m;
    int          k, e;
    m = $urandom;
    k = int'($urandom_range(0, 11));
    e = center + int'($urandom_range(0, 6)) - 3;
    if (e < 1) e = 1;
    if (e > 254) e = 254;
    if (k == 0) return {m[31], 31'b0};
    if (k == 1) return {m[31], 8'd0, m[22:0]};
    return {m[31], 8'(e), m[22:0]};
  endfunction

  task automatic pack;
    for (int i = 0; i < 16; i++) vals[511 - 32*i -: 32] = v[i];
  endtask

  task automatic grab(input int t);
    o_sum[0][t] = i_sum; o_rdy[0][t] = i_rdy; o_in0[0][t] = i_in0; o_in1[0][t] = i_in1;
    o_sum[1][t] = f_sum; o_rdy[1][t] = f_rdy; o_in0[1][t] = f_in0; o_in1[1][t] = f_in1;
    if (t == 3) begin
      o_lane[0][0] = i_s0; o_lane[0][1] = i_s1; o_lane[0][2] = i_s2; o_lane[0][3] = i_s3;
      o_lane[1][0] = f_s0; o_lane[1][1] = f_s1; o_lane[1][2] = f_s2; o_lane[1][3] = f_s3;
    end
  endtask

  // One operation: EN for one edge, vals scrambled after E0; sample index t = negedge after E(t).
  task automatic run_op;
    prev[0] = i_sum;
    prev[1] = f_sum;
    model;
    pack;
    EN = 1'b1;
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      if (t == 0) begin
        EN = 1'b0;
        for (int i = 0; i < 16; i++) vals[511 - 32*i -: 32] = $urandom;
      end
      grab(t);
    end
  endtask

  task automatic test_reset;
    checks++; if (i_sum !== 32'h0 || i_rdy !== 1'b0) begin errors++; $display("FAIL reset_int: sum=%h rdy=%b expected 0/0", i_sum, i_rdy); end
    checks++; if (f_sum !== 32'h0 || f_rdy !== 1'b0) begin errors++; $display("FAIL reset_flt: sum=%h rdy=%b expected 0/0", f_sum, f_rdy); end
    checks++; if ({i_in0, i_in1, i_s0, i_s1, i_s2, i_s3} !== 192'h0) begin errors++; $display("FAIL reset_int_dbg: got nonzero debug outputs expected 0"); end
    checks++; if ({f_in0, f_in1, f_s0, f_s1, f_s2, f_s3} !== 192'h0) begin errors++; $display("FAIL reset_flt_dbg: got nonzero debug outputs expected 0"); end
  endtask

  task automatic test_float_ones;
    for (int i = 0; i < 16; i++) v[i] = 32'h3F800000;
    run_op;
    for (int m = 0; m < 2; m++)
      for (int t = 0; t < 6; t++) begin
        checks++;
        if (o_rdy[m][t] !== 1'b0 || o_sum[m][t] !== prev[m]) begin
          errors++; $display("FAIL ones_hold m%0d t%0d: rdy=%b sum=%h expected 0/%h", m, t, o_rdy[m][t], o_sum[m][t], prev[m]);
        end
      end
    checks++; if (o_rdy[1][6] !== 1'b1) begin errors++; $display("FAIL ones_rdy: got %b expected 1", o_rdy[1][6]); end
    checks++; if (o_sum[1][6] !== 32'h41800000) begin errors++; $display("FAIL ones_fsum: got %h expected 41800000", o_sum[1][6]); end
    checks++; if (o_sum[0][6] !== 32'hF8000000) begin errors++; $display("FAIL ones_isum: got %h expected f8000000", o_sum[0][6]); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (o_lane[1][k] !== dbg(32'h40800000)) begin errors++; $display("FAIL ones_lane%0d: got %h expected %h", k, o_lane[1][k], dbg(32'h40800000)); end
    end
    checks++; if (o_in0[1][3] !== dbg(32'h40800000) || o_in1[1][3] !== dbg(32'h40800000)) begin errors++; $display("FAIL ones_comb1: got %h/%h expected %h", o_in0[1][3], o_in1[1][3], dbg(32'h40800000)); end
    checks++; if (o_in0[1][4] !== dbg(32'h41000000) || o_in1[1][4] !== dbg(32'h40800000)) begin errors++; $display("FAIL ones_comb2: got %h/%h", o_in0[1][4], o_in1[1][4]); end
    checks++; if (o_in0[1][5] !== dbg(32'h41400000) || o_in1[1][5] !== dbg(32'h40800000)) begin errors++; $display("FAIL ones_comb3: got %h/%h", o_in0[1][5], o_in1[1][5]); end
    checks++; if (o_in0[1][6] !== 32'h0 || o_in1[1][6] !== 32'h0) begin errors++; $display("FAIL ones_done_in: got %h/%h expected 0/0", o_in0[1][6], o_in1[1][6]); end
  endtask

  task automatic test_single;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) v[i] = 32'h0;
      v[pass == 0 ? 15 : 0] = 32'h3F800000;
      run_op;
      checks++; if (o_sum[1][6] !== 32'h3F800000) begin errors++; $display("FAIL single_p%0d: got %h expected 3f800000", pass, o_sum[1][6]); end
    end
  endtask

  task automatic test_int_wrap;
    for (int i = 0; i < 16; i++) v[i] = 32'h00000001;
    run_op;
    checks++; if (o_sum[0][6] !== 32'h00000010) begin errors++; $display("FAIL int_ones: got %h expected 00000010", o_sum[0][6]); end
    for (int i = 0; i < 16; i++) v[i] = 32'hFFFFFFFF;
    run_op;
    checks++; if (o_sum[0][6] !== 32'hFFFFFFF0) begin errors++; $display("FAIL int_wrap: got %h expected fffffff0", o_sum[0][6]); end
    checks++; if (o_sum[1][6] !== 32'h7FC00000) begin errors++; $display("FAIL nan_ones: got %h expected 7fc00000", o_sum[1][6]); end
  endtask

  task automatic test_decimal;
    real r [16] = '{1.0e-7, 1.0, 2.0, 3.586, 4.0009, 5.388, 6.0, 7.983,
                    800.0, 90.3008, 10.0, 11.2008, 12.387, 13.16, 140000.0, 0.015};
    logic [31:0] want;
    int          diff;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) v[i] = r2f(pass == 0 ? r[i] : -r[i]);
      want = (pass == 0) ? 32'h4809A9C1 : 32'hC809A9C1;
      run_op;
      diff = int'(o_sum[1][6]) - int'(want);
      checks++; if (diff > 1 || diff < -1) begin errors++; $display("FAIL decimal_p%0d: got %h expected %h +-1", pass, o_sum[1][6], want); end
      checks++; if (o_sum[1][6] !== e_sum[1]) begin errors++; $display("FAIL decimal_model_p%0d: got %h expected %h", pass, o_sum[1][6], e_sum[1]); end
    end
  endtask

  task automatic test_inf_nan;
    for (int i = 0; i < 16; i++) v[i] = rand_f(127);
    v[1] = 32'h7F800000;
    v[9] = 32'hFF800000;
    run_op;
    checks++; if (o_sum[1][6] !== 32'h7FC00000) begin errors++; $display("FAIL inf_minus_inf: got %h expected 7fc00000", o_sum[1][6]); end
  endtask

  task automatic test_random;
    int c;
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: c = 3;
        1: c = 251;
        default: c = int'($urandom_range(100, 150));
      endcase
      for (int i = 0; i < 16; i++) v[i] = rand_f(c);
      run_op;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (o_sum[m][6] !== e_sum[m] || o_rdy[m][6] !== 1'b1) begin
          errors++; $display("FAIL random it%0d m%0d: sum=%h rdy=%b expected %h/1", it, m, o_sum[m][6], o_rdy[m][6], e_sum[m]);
        end
        checks++;
        if ({o_lane[m][0], o_lane[m][1], o_lane[m][2], o_lane[m][3]} !==
            {dbg(e_lane[m][0]), dbg(e_lane[m][1]), dbg(e_lane[m][2]), dbg(e_lane[m][3])}) begin
          errors++; $display("FAIL random_lanes it%0d m%0d: got %h %h %h %h expected %h %h %h %h", it, m,
                             o_lane[m][0], o_lane[m][1], o_lane[m][2], o_lane[m][3],
                             dbg(e_lane[m][0]), dbg(e_lane[m][1]), dbg(e_lane[m][2]), dbg(e_lane[m][3]));
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a_sum [2];
    for (int i = 0; i < 16; i++) v[i] = rand_f(125);
    model;
    a_sum = e_sum;
    pack;
    EN = 1'b1;
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      if (t == 0) begin
        for (int i = 0; i < 16; i++) v[i] = rand_f(125);
        model;
        pack;
      end
      grab(t);
    end
    EN = 1'b0;
    for (int m = 0; m < 2; m++) begin
      checks++; if (o_rdy[m][6] !== 1'b1 || o_sum[m][6] !== a_sum[m]) begin errors++; $display("FAIL b2b_first m%0d: rdy=%b sum=%h expected 1/%h", m, o_rdy[m][6], o_sum[m][6], a_sum[m]); end
      checks++; if (o_rdy[m][7] !== 1'b0 || o_sum[m][7] !== a_sum[m]) begin errors++; $display("FAIL b2b_restart m%0d: rdy=%b sum=%h expected 0/%h", m, o_rdy[m][7], o_sum[m][7], a_sum[m]); end
      checks++; if (o_rdy[m][12] !== 1'b0) begin errors++; $display("FAIL b2b_early m%0d: rdy=%b expected 0", m, o_rdy[m][12]); end
      checks++; if (o_rdy[m][13] !== 1'b1 || o_sum[m][13] !== e_sum[m]) begin errors++; $display("FAIL b2b_second m%0d: rdy=%b sum=%h expected 1/%h", m, o_rdy[m][13], o_sum[m][13], e_sum[m]); end
    end
  endtask

  task automatic test_reset_midop;
    for (int i = 0; i < 16; i++) v[i] = rand_f(130);
    pack;
    EN = 1'b1;
    @(negedge clk);
    EN = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    test_reset;
    @(negedge clk);
    test_reset;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) v[i] = 32'hFFFFFFFF;
    run_op;
    for (int m = 0; m < 2; m++) begin
      checks++; if (o_rdy[m][5] !== 1'b0 || o_sum[m][5] !== 32'h0) begin errors++; $display("FAIL rst_restart_t5 m%0d: rdy=%b sum=%h expected 0/0", m, o_rdy[m][5], o_sum[m][5]); end
      checks++; if (o_rdy[m][6] !== 1'b1) begin errors++; $display("FAIL rst_restart_rdy m%0d: got %b expected 1", m, o_rdy[m][6]); end
    end
    checks++; if (o_sum[0][6] !== 32'hFFFFFFF0) begin errors++; $display("FAIL rst_restart_isum: got %h expected fffffff0", o_sum[0][6]); end
    checks++; if (o_sum[1][6] !== 32'h7FC00000) begin errors++; $display("FAIL rst_restart_fsum: got %h expected 7fc00000", o_sum[1][6]); end
  endtask

  initial begin
    rst  = 1'b1;
    EN   = 1'b0;
    vals = '0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_float_ones;
    test_single;
    test_int_wrap;
    test_decimal;
    test_inf_nan;
    test_random;
    test_back_to_back;
    test_reset_midop;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
